// File: rtl/wrr_arbiter.sv
// wrr_arbiter: weighted round-robin arbiter with registered one-hot grant
// Ports:
//   clk         - rising-edge clock
//   reset       - asynchronous active-low reset
//   request     - per-requester level request, N bits
//   weight      - per-requester burst length, field [i*WW +: WW], 0 acts as 1
//   lock        - holder keeps grant with frozen count (only with WRR_LOCK_EN)
//   grant       - registered one-hot grant or zero
//   grant_id    - binary index of the holder, 0 when idle
//   grant_valid - |grant
// Optional feature macro: WRR_LOCK_EN
module wrr_arbiter #(
    parameter int N  = 4,
    parameter int WW = 4,
    parameter int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    request,
    input  logic [N*WW-1:0] weight,
`ifdef WRR_LOCK_EN
    input  logic            lock,
`endif
    output logic [N-1:0]    grant,
    output logic [IW-1:0]   grant_id,
    output logic            grant_valid
);
    localparam logic [IW:0] LN = (IW+1)'(N);

    logic [N-1:0]  r_grant;
    logic [IW-1:0] r_id;
    logic [IW-1:0] r_ptr;
    logic [WW-1:0] r_cnt;
    logic [N-1:0]  w_rot;
    logic [IW-1:0] w_off;
    logic [IW-1:0] w_nxt;
    logic [IW-1:0] w_ptr_n;
    logic [IW:0]   w_sum;
    logic [IW:0]   w_inc;
    logic [WW-1:0] w_wt;
    logic [WW-1:0] w_eff;
    logic          w_found;
    logic          w_hold;
    logic          w_lock;

    // Rotate so bit k is requester (ptr+k) mod N; lowest set bit wins.
    assign w_rot = N'({request, request} >> r_ptr);

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int k = N - 1; k >= 0; k--)
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = IW'(k);
            end
    end

    assign w_sum   = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_nxt   = (w_sum >= LN) ? IW'(w_sum - LN) : w_sum[IW-1:0];
    assign w_inc   = {1'b0, w_nxt} + (IW+1)'(1);
    assign w_ptr_n = (w_inc == LN) ? '0 : w_inc[IW-1:0];

    always_comb begin
        w_wt = '0;
        for (int k = 0; k < N; k++)
            if (w_nxt == IW'(k)) w_wt = weight[k*WW +: WW];
    end

    assign w_eff  = (w_wt == '0) ? WW'(1) : w_wt;
    assign w_hold = grant_valid && request[r_id] && (r_cnt > WW'(1));
`ifdef WRR_LOCK_EN
    assign w_lock = grant_valid && request[r_id] && lock;
`else
    assign w_lock = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant <= '0;
            r_id    <= '0;
            r_cnt   <= '0;
            r_ptr   <= '0;
        end else if (w_lock) begin
            r_cnt   <= r_cnt;
        end else if (w_hold) begin
            r_cnt   <= r_cnt - WW'(1);
        end else if (w_found) begin
            r_grant <= N'(1) << w_nxt;
            r_id    <= w_nxt;
            r_cnt   <= w_eff;
            r_ptr   <= w_ptr_n;
        end else begin
            r_grant <= '0;
            r_id    <= '0;
            r_cnt   <= '0;
        end
    end

    assign grant       = r_grant;
    assign grant_id    = r_id;
    assign grant_valid = |r_grant;
endmodule

// File: tb/tb_wrr_arbiter.sv
// tb_wrr_arbiter: vector table, corner sequences and randomized model check
module tb_wrr_arbiter;
    localparam int N  = 4;
    localparam int WW = 4;

    typedef struct {
        bit          rst;
        logic [3:0]  req;
        logic [15:0] wt;
        logic [3:0]  eg;
        logic [1:0]  eid;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  request = '0;
    logic [15:0] weight = '0;
`ifdef WRR_LOCK_EN
    logic        lock = 1'b0;
`endif
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic        grant_valid;

    int checks = 0;
    int errors = 0;
    int m_gnt = -1;
    int m_cnt = 0;
    int m_ptr = 0;
    vec_t v[$];

    always #5 clk = ~clk;

    wrr_arbiter #(.N(N), .WW(WW)) dut (
        .clk(clk),
        .reset(reset),
        .request(request),
        .weight(weight),
`ifdef WRR_LOCK_EN
        .lock(lock),
`endif
        .grant(grant),
        .grant_id(grant_id),
        .grant_valid(grant_valid)
    );

    task automatic cmp(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic chk(string nm, logic [3:0] eg, logic [1:0] eid);
        cmp({nm, " grant"}, int'(grant), int'(eg));
        cmp({nm, " grant_id"}, int'(grant_id), int'(eid));
        cmp({nm, " grant_valid"}, int'(grant_valid), int'(|eg));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(bit r, logic [3:0] q, logic [15:0] w, logic [3:0] g, logic [1:0] i);
        v.push_back('{r, q, w, g, i});
    endtask

    task automatic model_reset();
        m_gnt = -1;
        m_cnt = 0;
        m_ptr = 0;
    endtask

    // Reference: spec rules applied to integer holder/count/pointer.
    task automatic model_edge();
        bit lk = 1'b0;
        bit live;
`ifdef WRR_LOCK_EN
        lk = lock;
`endif
        live = (m_gnt >= 0) && request[m_gnt];
        if (live && lk) return;
        if (live && m_cnt > 1) begin
            m_cnt--;
            return;
        end
        for (int k = 0; k < N; k++) begin
            int idx = (m_ptr + k) % N;
            if (request[idx]) begin
                int w = int'((weight >> (idx * WW)) & 16'hF);
                m_gnt = idx;
                m_cnt = (w == 0) ? 1 : w;
                m_ptr = (idx + 1) % N;
                return;
            end
        end
        m_gnt = -1;
        m_cnt = 0;
    endtask

    task automatic model_chk(string nm);
        chk(nm, (m_gnt < 0) ? 4'd0 : 4'(1 << m_gnt), (m_gnt < 0) ? 2'd0 : 2'(m_gnt));
    endtask

    initial begin
        add(1, 4'hF, 16'h1111, 4'h0, 0);
        add(0, 4'hF, 16'h1111, 4'h1, 0);
        add(0, 4'hF, 16'h1111, 4'h2, 1);
        add(0, 4'hF, 16'h1111, 4'h4, 2);
        add(0, 4'hF, 16'h1111, 4'h8, 3);
        add(0, 4'hF, 16'h1111, 4'h1, 0);
        add(1, 4'hF, 16'h1113, 4'h0, 0);
        for (int k = 0; k < 3; k++) add(0, 4'hF, 16'h1113, 4'h1, 0);
        add(0, 4'hF, 16'h1113, 4'h2, 1);
        add(0, 4'hF, 16'h1113, 4'h4, 2);
        add(0, 4'hF, 16'h1113, 4'h8, 3);
        for (int k = 0; k < 3; k++) add(0, 4'hF, 16'h1113, 4'h1, 0);
        add(1, 4'hF, 16'h1110, 4'h0, 0);
        add(0, 4'hF, 16'h1110, 4'h1, 0);
        add(0, 4'hF, 16'h1110, 4'h2, 1);
        add(0, 4'hF, 16'h1110, 4'h4, 2);
        add(0, 4'hF, 16'h1110, 4'h8, 3);
        add(0, 4'hF, 16'h1110, 4'h1, 0);
        add(1, 4'hB, 16'h2222, 4'h0, 0);
        for (int r = 0; r < 2; r++) begin
            add(0, 4'hB, 16'h2222, 4'h1, 0);
            add(0, 4'hB, 16'h2222, 4'h1, 0);
            add(0, 4'hB, 16'h2222, 4'h2, 1);
            add(0, 4'hB, 16'h2222, 4'h2, 1);
            add(0, 4'hB, 16'h2222, 4'h8, 3);
            add(0, 4'hB, 16'h2222, 4'h8, 3);
        end
        add(1, 4'h4, 16'h1111, 4'h0, 0);
        for (int k = 0; k < 4; k++) add(0, 4'h4, 16'h1111, 4'h4, 2);
        add(0, 4'h0, 16'h1111, 4'h0, 0);
        add(0, 4'hF, 16'h1111, 4'h8, 3);

        foreach (v[k]) begin
            request = v[k].req;
            weight  = v[k].wt;
            if (v[k].rst) begin
                reset = 1'b0;
                #1;
                chk($sformatf("vec%0d reset", k), v[k].eg, v[k].eid);
                reset = 1'b1;
            end else begin
                tick();
                chk($sformatf("vec%0d", k), v[k].eg, v[k].eid);
            end
        end

        // Asynchronous reset in the middle of requester 2's burst.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        weight  = 16'h0400;
        request = 4'b0100;
        tick();
        chk("burst2 start", 4'h4, 2);
        tick();
        chk("burst2 hold", 4'h4, 2);
        #1;
        reset = 1'b0;
        #1;
        chk("async reset", 4'h0, 0);
        reset = 1'b1;
        request = 4'hF;
        weight  = 16'h1111;
        tick();
        chk("after reset", 4'h1, 0);

`ifdef WRR_LOCK_EN
        tick();
        chk("pre lock", 4'h2, 1);
        lock = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("lock%0d", k), 4'h2, 1);
        end
        lock = 1'b0;
        tick();
        chk("unlock", 4'h4, 2);
`endif

        reset = 1'b0;
        #1;
        reset = 1'b1;
        model_reset();
        request = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) request = 4'($urandom);
            if ($urandom_range(0, 7) == 0) weight = 16'($urandom);
`ifdef WRR_LOCK_EN
            if ($urandom_range(0, 3) == 0) lock = 1'($urandom);
`endif
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                model_reset();
                #1;
                model_chk("rand reset");
                reset = 1'b1;
            end
            @(posedge clk);
            model_edge();
            #1;
            model_chk($sformatf("rand%0d", c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
